// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO block: register map, STATUS/CTRL bit
// positions and default FIFO depth.
package uart_mmio_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned BYTE_W             = 8;

  // Register select, taken from byte offset bits [3:2]
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,  // 0x0
    REG_RX_DATA = 2'd1,  // 0x4
    REG_TX_DATA = 2'd2,  // 0x8
    REG_CTRL    = 2'd3   // 0xC
  } reg_sel_e;

  localparam int unsigned ST_TX_NOT_FULL  = 0;
  localparam int unsigned ST_RX_NOT_EMPTY = 1;
  localparam int unsigned ST_RX_OVERFLOW  = 2;
  localparam int unsigned ST_TX_DROP      = 3;
  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_COUNT_LSB = 12;
  localparam int unsigned ST_COUNT_W      = 4;

  localparam int unsigned CTRL_CLR_STICKY = 0;
  localparam int unsigned CTRL_FLUSH      = 1;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with simultaneous push/pop (also when full), flush and
// occupancy count. The head reads as zero while empty.
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head_c,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full_c,
  output logic             o_empty_c
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty_c = (r_count == '0);
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head_c  = o_empty_c ? '0 : r_mem[r_rd_ptr];

  // A pop frees the slot that a same-cycle push into a full FIFO needs
  assign w_pop  = i_pop & ~o_empty_c;
  assign w_push = i_push & (~o_full_c | w_pop);

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_mmio.sv
// CPU-facing register block bridging 32-bit MMIO accesses to UART byte
// streams through a TX and an RX FIFO.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mmio_sel,
  input  logic              mmio_we,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic [31:0]       mmio_wdata,
  output logic [31:0]       mmio_rdata,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] r_rdata;
  logic              r_rx_overflow;
  logic              r_tx_drop;
  logic              r_rx_ready;

  reg_sel_e          w_reg;
  logic              w_rd, w_wr, w_flush, w_clr;
  logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_drop;
  logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop;
  logic [CNT_W-1:0]  w_tx_count, w_rx_count;
  logic [BYTE_W-1:0] w_tx_head, w_rx_head;
  logic [DATA_W-1:0] w_status;
  logic              w_unused;

  assign w_reg   = reg_sel_e'(mmio_addr[3:2]);
  assign w_rd    = mmio_sel & ~mmio_we;
  assign w_wr    = mmio_sel & mmio_we;
  assign w_flush = w_wr & (w_reg == REG_CTRL) & mmio_wdata[CTRL_FLUSH];
  assign w_clr   = w_wr & (w_reg == REG_CTRL) & mmio_wdata[CTRL_CLR_STICKY];

  assign w_tx_push = w_wr & (w_reg == REG_TX_DATA);
  assign w_tx_pop  = ~w_tx_empty & uart_tx_ready;
  assign w_tx_drop = w_tx_push & w_tx_full & ~w_tx_pop & ~w_flush;

  assign w_rx_push = uart_rx_valid & r_rx_ready;
  assign w_rx_pop  = w_rd & (w_reg == REG_RX_DATA) & ~w_rx_empty;
  // A flush discards a concurrent incoming byte silently
  assign w_rx_drop = w_rx_push & w_rx_full & ~w_rx_pop & ~w_flush;

  assign w_unused = ^{mmio_addr, mmio_wdata[31:8]};

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .clk      (clk),
    .i_rst_n  (reset),
    .i_push   (w_tx_push),
    .i_pop    (w_tx_pop),
    .i_flush  (w_flush),
    .i_data   (mmio_wdata[7:0]),
    .o_head_c (w_tx_head),
    .o_count  (w_tx_count),
    .o_full_c (w_tx_full),
    .o_empty_c(w_tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk      (clk),
    .i_rst_n  (reset),
    .i_push   (w_rx_push),
    .i_pop    (w_rx_pop),
    .i_flush  (w_flush),
    .i_data   (uart_rx_data),
    .o_head_c (w_rx_head),
    .o_count  (w_rx_count),
    .o_full_c (w_rx_full),
    .o_empty_c(w_rx_empty)
  );

  always_comb begin
    w_status = '0;
    w_status[ST_TX_NOT_FULL]  = ~w_tx_full;
    w_status[ST_RX_NOT_EMPTY] = ~w_rx_empty;
    w_status[ST_RX_OVERFLOW]  = r_rx_overflow;
    w_status[ST_TX_DROP]      = r_tx_drop;
    w_status[ST_RX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_rx_count);
    w_status[ST_TX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_tx_count);
  end

  // Read data, sticky flags and RX ready; a same-cycle event beats a clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata       <= '0;
      r_rx_overflow <= 1'b0;
      r_tx_drop     <= 1'b0;
      r_rx_ready    <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      if (w_rd) begin
        case (w_reg)
          REG_STATUS:  r_rdata <= w_status;
          REG_RX_DATA: r_rdata <= DATA_W'(w_rx_head);
          default:     r_rdata <= '0;
        endcase
      end
      if (w_clr) begin
        r_rx_overflow <= 1'b0;
        r_tx_drop     <= 1'b0;
      end
      if (w_rx_drop) r_rx_overflow <= 1'b1;
      if (w_tx_drop) r_tx_drop     <= 1'b1;
    end
  end

  assign mmio_rdata    = r_rdata;
  assign uart_tx_valid = ~w_tx_empty;
  assign uart_tx_data  = w_tx_head;
  assign uart_rx_ready = r_rx_ready;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: a vector table for basic register/TX behaviour
// plus hand sequences for overflow, drop, flush and reset corner cases.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        mmio_sel, mmio_we;
  logic [3:0]  mmio_addr;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  uart_mmio #(.FIFO_DEPTH(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mmio_sel     (mmio_sel),
    .mmio_we      (mmio_we),
    .mmio_addr    (mmio_addr),
    .mmio_wdata   (mmio_wdata),
    .mmio_rdata   (mmio_rdata),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        txr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus/stream cycle: drive at negedge, sample 1 time unit after posedge
  task automatic drive(input logic sel, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic txr,
                       input logic rxv, input logic [7:0] rxd);
    @(negedge clk);
    mmio_sel = sel; mmio_we = we; mmio_addr = addr; mmio_wdata = wdata;
    uart_tx_ready = txr; uart_rx_valid = rxv; uart_rx_data = rxd;
    @(posedge clk);
    #1;
    mmio_sel = 1'b0; mmio_we = 1'b0; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, addr, 32'h0, 1'b0, 1'b0, 8'h0);
    check(name, mmio_rdata, exp);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    drive(1'b1, 1'b1, addr, data, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, d);
  endtask

  initial begin
    //             sel   we    addr  wdata   txr   chk   exp_rd        txv   txd
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0001, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 4'h8, 32'h41, 1'b0, 1'b0, 32'h0,         1'b1, 8'h41};
    vecs[2]  = '{1'b1, 1'b1, 4'h8, 32'h42, 1'b0, 1'b0, 32'h0,         1'b1, 8'h41};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_2001, 1'b1, 8'h41};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b1, 32'h0000_2001, 1'b1, 8'h42};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b1, 32'h0000_2001, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0001, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0001, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 4'h8, 32'h0,  1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 32'hFF, 1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0,  1'b0, 1'b1, 32'h0000_0001, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 4'hC, 32'h3,  1'b0, 1'b1, 32'h0000_0001, 1'b0, 8'h00};

    reset = 1'b0; mmio_sel = 1'b0; mmio_we = 1'b0; mmio_addr = 4'h0; mmio_wdata = 32'h0;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", mmio_rdata, 32'h0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("rst_tx_data", 32'(uart_tx_data), 32'h0);
    check("rst_rx_ready", 32'(uart_rx_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rx_ready_after_rst", 32'(uart_rx_ready), 32'h1);

    // Table: STATUS after reset, TX handoff, hold, unmapped accesses
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].txr, 1'b0, 8'h0);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), mmio_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_tx_valid", i), 32'(uart_tx_valid), 32'(vecs[i].exp_txv));
      check($sformatf("vec%0d_tx_data", i), 32'(uart_tx_data), 32'(vecs[i].exp_txd));
    end

    // TX overfill, sticky clear, push+pop while full
    for (int i = 0; i < 9; i++) wr(4'h8, 32'h60 + 32'(i));
    rd(4'h0, 32'h0000_8008, "tx_full_status");
    check("tx_full_head", 32'(uart_tx_data), 32'h60);
    wr(4'hC, 32'h1);
    rd(4'h0, 32'h0000_8000, "tx_drop_cleared");
    drive(1'b1, 1'b1, 4'h8, 32'h70, 1'b1, 1'b0, 8'h0);
    check("tx_pushpop_full_head", 32'(uart_tx_data), 32'h61);
    rd(4'h0, 32'h0000_8000, "tx_pushpop_full_status");
    wr(4'hC, 32'h2);
    rd(4'h0, 32'h0000_0001, "tx_flushed");

    // RX overflow and drain
    for (int i = 0; i < 9; i++) rx_byte(8'h10 + 8'(i));
    rd(4'h0, 32'h0000_0807, "rx_ovf_status");
    for (int i = 0; i < 8; i++) rd(4'h4, 32'h10 + 32'(i), $sformatf("rx_drain%0d", i));
    rd(4'h4, 32'h0, "rx_empty_read");
    rd(4'h0, 32'h0000_0005, "rx_ovf_sticky");
    wr(4'hC, 32'h1);
    rd(4'h0, 32'h0000_0001, "rx_ovf_cleared");

    // RX full: read and incoming byte in the same cycle
    for (int i = 0; i < 8; i++) rx_byte(8'h20 + 8'(i));
    drive(1'b1, 1'b0, 4'h4, 32'h0, 1'b0, 1'b1, 8'h55);
    check("rx_full_pushpop_rdata", mmio_rdata, 32'h20);
    rd(4'h0, 32'h0000_0803, "rx_full_pushpop_status");
    for (int i = 0; i < 7; i++) rd(4'h4, 32'h21 + 32'(i), $sformatf("rx_pp_drain%0d", i));
    rd(4'h4, 32'h55, "rx_pp_last");
    rd(4'h0, 32'h0000_0001, "rx_pp_empty");

    // Sticky clear coinciding with a new overflow: overflow stays set
    for (int i = 0; i < 8; i++) rx_byte(8'h30 + 8'(i));
    drive(1'b1, 1'b1, 4'hC, 32'h1, 1'b0, 1'b1, 8'h99);
    rd(4'h0, 32'h0000_0807, "clr_vs_set");
    wr(4'hC, 32'h3);
    rd(4'h0, 32'h0000_0001, "clr_flush");

    // Flush coinciding with an incoming byte, both FIFOs non-empty
    wr(4'h8, 32'h33);
    rx_byte(8'h44);
    rd(4'h0, 32'h0000_1103, "pre_flush_status");
    drive(1'b1, 1'b1, 4'hC, 32'h2, 1'b0, 1'b1, 8'h99);
    check("flush_tx_valid", 32'(uart_tx_valid), 32'h0);
    rd(4'h0, 32'h0000_0001, "flush_vs_rx");

    // Reset mid-transfer
    wr(4'h8, 32'h77);
    rx_byte(8'h88);
    @(negedge clk);
    reset = 1'b0; mmio_sel = 1'b1; mmio_we = 1'b0; mmio_addr = 4'h0;
    @(posedge clk);
    #1;
    check("midrst_rdata", mmio_rdata, 32'h0);
    check("midrst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("midrst_tx_data", 32'(uart_tx_data), 32'h0);
    check("midrst_rx_ready", 32'(uart_rx_ready), 32'h0);
    mmio_sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rx_ready_back", 32'(uart_rx_ready), 32'h1);
    rd(4'h0, 32'h0000_0001, "midrst_status");
    rd(4'h4, 32'h0, "midrst_rx_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
